riscboy_ppu_pixel_unpacker: RTL

- Receives the halfword read data returned for pixel fetches, plus the per-pixel metadata (pinfo) queued by the pixel address generator.
- Extracts one pixel per pinfo entry according to the span's pixel mode.
- Emits a valid/ready pixel stream to the blender/palette stage.
- Pixels flagged discard (out-of-bounds blit or discarded tile) pass through as discard markers without consuming bus data.

---
 rtl/riscboy_ppu_pixel_unpacker.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/riscboy_ppu_pixel_unpacker.sv
// Pixel unpacker: buffers halfword read data and extracts one pixel per pinfo
// entry according to the span's pixel mode, producing a valid/ready pixel stream.
module riscboy_ppu_pixel_unpacker #(
  parameter int W_DATA         = 16,
  parameter int DATA_BUF_DEPTH = 5,
  parameter int W_BUF_LEVEL    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              span_start,
  input  logic [1:0]        span_pixmode,
  input  logic              bus_data_vld,
  input  logic [W_DATA-1:0] bus_data,
  input  logic [3:0]        pinfo_u,
  input  logic              pinfo_discard,
  input  logic              pinfo_vld,
  output logic              pinfo_rdy,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [W_DATA-1:0] out_data,
  output logic              out_paletted,
  output logic              out_discard,
  output logic              data_overflow
);

  localparam int W_PTR = (DATA_BUF_DEPTH > 1) ? $clog2(DATA_BUF_DEPTH) : 1;
  localparam logic [W_BUF_LEVEL-1:0] LEVEL_FULL = W_BUF_LEVEL'(DATA_BUF_DEPTH);
  localparam logic [W_PTR-1:0]       PTR_LAST   = W_PTR'(DATA_BUF_DEPTH - 1);

  typedef enum logic [1:0] {
    MODE_ARGB1555 = 2'd0,
    MODE_PAL8     = 2'd1,
    MODE_PAL4     = 2'd2,
    MODE_PAL1     = 2'd3
  } pixmode_t;

  pixmode_t                pixmode_q, pixmode_d;
  logic [W_DATA-1:0]       buf_q [DATA_BUF_DEPTH];
  logic [W_DATA-1:0]       buf_d [DATA_BUF_DEPTH];
  logic [W_PTR-1:0]        wptr_q, wptr_d;
  logic [W_PTR-1:0]        rptr_q, rptr_d;
  logic [W_BUF_LEVEL-1:0]  level_q, level_d;
  logic                    overflow_q, overflow_d;
  logic                    out_vld_q, out_vld_d;
  logic [W_DATA-1:0]       out_data_q, out_data_d;
  logic                    out_paletted_q, out_paletted_d;
  logic                    out_discard_q, out_discard_d;

  logic                    buf_empty;
  logic                    buf_full;
  logic                    load_en;
  logic                    buf_pop;
  logic                    buf_push;
  logic [W_DATA-1:0]       head;
  logic [7:0]              index;
  logic [W_DATA-1:0]       extracted;

  assign buf_empty = (level_q == '0);
  assign buf_full  = (level_q == LEVEL_FULL);
  assign load_en   = !out_vld_q || out_rdy;
  assign pinfo_rdy = pinfo_vld && load_en && (pinfo_discard || !buf_empty);
  assign buf_pop   = pinfo_rdy && !pinfo_discard;
  // A pop in the same cycle frees the slot, so a full buffer can still accept.
  assign buf_push  = bus_data_vld && (!buf_full || buf_pop);
  assign head      = buf_q[rptr_q];

  always_comb begin
    buf_d      = buf_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    overflow_d = overflow_q || (bus_data_vld && !buf_push);
    pixmode_d  = span_start ? pixmode_t'(span_pixmode) : pixmode_q;
    if (buf_push) begin
      buf_d[wptr_q] = bus_data;
      wptr_d        = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
    end
    if (buf_pop) begin
      rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
    end
    case ({buf_push, buf_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    index = 8'h00;
    case (pixmode_q)
      MODE_PAL8: index = head[{pinfo_u[0], 3'b000} +: 8];
      MODE_PAL4: index = {4'h0, head[{pinfo_u[1:0], 2'b00} +: 4]};
      MODE_PAL1: index = {7'h00, head[pinfo_u]};
      default:   index = 8'h00;
    endcase
    extracted = (pixmode_q == MODE_ARGB1555) ? head : {{(W_DATA-8){1'b0}}, index};
  end

  always_comb begin
    out_vld_d      = out_vld_q;
    out_data_d     = out_data_q;
    out_paletted_d = out_paletted_q;
    out_discard_d  = out_discard_q;
    if (pinfo_rdy) begin
      out_vld_d      = 1'b1;
      out_data_d     = pinfo_discard ? '0 : extracted;
      out_paletted_d = (pixmode_q != MODE_ARGB1555);
      out_discard_d  = pinfo_discard;
    end else if (out_rdy) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixmode_q      <= MODE_ARGB1555;
      for (int i = 0; i < DATA_BUF_DEPTH; i++) buf_q[i] <= '0;
      wptr_q         <= '0;
      rptr_q         <= '0;
      level_q        <= '0;
      overflow_q     <= 1'b0;
      out_vld_q      <= 1'b0;
      out_data_q     <= '0;
      out_paletted_q <= 1'b0;
      out_discard_q  <= 1'b0;
    end else begin
      pixmode_q      <= pixmode_d;
      buf_q          <= buf_d;
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      level_q        <= level_d;
      overflow_q     <= overflow_d;
      out_vld_q      <= out_vld_d;
      out_data_q     <= out_data_d;
      out_paletted_q <= out_paletted_d;
      out_discard_q  <= out_discard_d;
    end
  end

  assign out_vld       = out_vld_q;
  assign out_data      = out_data_q;
  assign out_paletted  = out_paletted_q;
  assign out_discard   = out_discard_q;
  assign data_overflow = overflow_q;

endmodule
